mc_control_unit: RTL and testbench
==================================

# mc_control_unit

Multi-cycle control unit for the MIPS-subset datapath: the next generation of the single-cycle decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, drives per-state datapath strobes, and handles a variable-latency memory through a ready handshake. It adds an optional extended instruction set and a retired-instruction counter. It sits between the instruction register/ALU flags and the shared-memory multi-cycle datapath.

## Interface
- EXT_ISA, 1, 1 enables bne, j, jalr; 0 makes them illegal
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- op  in  6  IR[31:26], valid from DECODE onward
- func  in  6  IR[5:0]
- zero  in  1  ALU result == 0, valid in EXEC
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory access request (fetch or data)
- mem_we  out  1  write strobe, with mem_req only
- ir_write  out  1  latch IR
- pc_write  out  1  update PC
- pc_sel  out  2  00 PC+4, 01 branch target, 10 jump target, 11 rs
- reg_write  out  1  GRF write enable
- reg_dst  out  2  00 rt, 01 rd, 10 $31
- wd_sel  out  2  00 ALU, 01 mem data, 10 lui immediate, 11 PC register (already PC+4)
- alu_op  out  3  000 AND, 001 OR, 010 ADD, 011 SUB
- ext_sel  out  2  00 zero-ext, 01 sign-ext
- alu_b_sel  out  1  0 rt, 1 extended immediate
- state  out  3  current state encoding
- instr_done  out  1  one-cycle pulse on last cycle of each retired instruction
- illegal  out  1  one-cycle pulse in DECODE for an unsupported encoding
- instr_count  out  CNT_W  retired instructions

## Operation
- Supported: add, sub, jr, lw, sw, beq, ori, lui, jal; with EXT_ISA=1 also bne (op 000101), j (000010), jalr (R, func 001001, rd<-PC).
- FETCH (0): mem_req=1, mem_we=0. Hold until mem_ready; on that cycle ir_write=1, pc_write=1, pc_sel=00, next DECODE.
- DECODE (1): illegal -> pulse illegal, no writes, next FETCH, no instr_done, no count. j/jal/jr/jalr complete here: pc_write=1 with pc_sel 10 or 11; jal: reg_write, reg_dst=10, wd_sel=11; jalr: reg_write, reg_dst=01, wd_sel=11; instr_done, next FETCH. All others -> EXEC.
- EXEC (2): alu_op/ext_sel/alu_b_sel per instruction (add ADD; sub, beq, bne SUB; ori OR zero-ext imm; lw/sw ADD sign-ext imm; lui no ALU use). beq: pc_write=zero, pc_sel=01; bne: pc_write=~zero; both retire -> FETCH. lw/sw -> MEM. R/ori/lui -> WB.
- MEM (3): mem_req=1, mem_we=sw. Hold until mem_ready; sw retires -> FETCH; lw -> WB.
- WB (4): reg_write=1; R: reg_dst=01, wd_sel=00; ori: 00/00; lui: 00/10; lw: 00/01. Retire -> FETCH.
- Control outputs are combinational from registered state, op, func, zero, mem_ready; state encodings 5..7 unreachable, treated as FETCH next, all strobes 0.
- instr_count increments on every instr_done; wraps modulo 2^CNT_W.

## Timing
- Reset: state=FETCH, instr_count=0; while reset high all strobes and pulses are 0. First cycle after reset: FETCH with mem_req=1.
- Latency with mem_ready tied high: j/jal/jr/jalr 2 cycles, beq/bne 3, R/ori/lui/sw 4, lw 5. Each mem_ready-low cycle in FETCH or MEM adds one.
- mem_req stays high, and address/data semantics unchanged, until mem_ready; mem_ready outside FETCH/MEM ignored.
- Reset mid-instruction aborts it: no write strobes that cycle, no retire, count unchanged besides clearing.
- instr_count updates the cycle after instr_done.

## Structure
- Package mc_ctrl_pkg: opcode/func constants, ALU op codes, state encodings, pc_sel/reg_dst/wd_sel encodings.
- Sub-module mc_ctrl_decode: purely combinational op/func -> instruction class and illegal flag (EXT_ISA parameter passed down); the FSM, strobe logic and counter live in mc_control_unit.

## Test plan
- Reset then add (op 0, func 100000), mem_ready=1 -> states 0,1,2,4; WB: reg_write=1, reg_dst=01, wd_sel=00; instr_count=1.
- lw with mem_ready low 2 cycles in MEM -> mem_req held 3 cycles, then WB wd_sel=01; total 7 cycles, one instr_done.
- beq zero=1 then zero=0 -> EXEC pc_write 1 then 0, pc_sel=01; both retire in 3 cycles.
- jal -> DECODE: pc_write=1, pc_sel=10, reg_write=1, reg_dst=10, wd_sel=11; 2 cycles.
- EXT_ISA=0, op 000101 -> illegal pulse, no writes, back to FETCH, count unchanged; EXT_ISA=1 same op -> bne executes.
- Reset asserted in MEM of sw -> mem_we=0 that cycle, state=FETCH, instr_count=0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit: states,
// opcodes/functs, datapath mux selects and the decoded instruction class.
package mc_ctrl_pkg;

  localparam int unsigned ST_W  = 3;
  localparam int unsigned OP_W  = 6;
  localparam int unsigned FN_W  = 6;
  localparam int unsigned ALU_W = 3;

  localparam logic [ST_W-1:0] ST_FETCH  = 3'd0;
  localparam logic [ST_W-1:0] ST_DECODE = 3'd1;
  localparam logic [ST_W-1:0] ST_EXEC   = 3'd2;
  localparam logic [ST_W-1:0] ST_MEM    = 3'd3;
  localparam logic [ST_W-1:0] ST_WB     = 3'd4;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  localparam logic [FN_W-1:0] FN_JR   = 6'b001000;
  localparam logic [FN_W-1:0] FN_JALR = 6'b001001;
  localparam logic [FN_W-1:0] FN_ADD  = 6'b100000;
  localparam logic [FN_W-1:0] FN_SUB  = 6'b100010;

  localparam logic [ALU_W-1:0] ALU_AND = 3'd0;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'd1;
  localparam logic [ALU_W-1:0] ALU_ADD = 3'd2;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'd3;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;

  localparam logic [1:0] REG_RT = 2'b00;
  localparam logic [1:0] REG_RD = 2'b01;
  localparam logic [1:0] REG_RA = 2'b10;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_LUI = 2'b10;
  localparam logic [1:0] WD_PC  = 2'b11;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;

  typedef enum logic [3:0] {
    CLS_ILL, CLS_ADD, CLS_SUB, CLS_JR, CLS_JALR, CLS_LW, CLS_SW,
    CLS_BEQ, CLS_BNE, CLS_ORI, CLS_LUI, CLS_J, CLS_JAL
  } instr_cls_e;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational op/func classifier; extended encodings fold to illegal when
// the extended ISA is disabled.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
#(
  parameter bit EXT_ISA = 1'b1
) (
  input  logic [OP_W-1:0] op_i,
  input  logic [FN_W-1:0] func_i,
  output instr_cls_e      cls_o,
  output logic            illegal_o
);

  always_comb begin
    cls_o = CLS_ILL;
    case (op_i)
      OP_RTYPE: begin
        case (func_i)
          FN_ADD:  cls_o = CLS_ADD;
          FN_SUB:  cls_o = CLS_SUB;
          FN_JR:   cls_o = CLS_JR;
          FN_JALR: if (EXT_ISA) cls_o = CLS_JALR;
          default: cls_o = CLS_ILL;
        endcase
      end
      OP_LW:   cls_o = CLS_LW;
      OP_SW:   cls_o = CLS_SW;
      OP_BEQ:  cls_o = CLS_BEQ;
      OP_ORI:  cls_o = CLS_ORI;
      OP_LUI:  cls_o = CLS_LUI;
      OP_JAL:  cls_o = CLS_JAL;
      OP_BNE:  if (EXT_ISA) cls_o = CLS_BNE;
      OP_J:    if (EXT_ISA) cls_o = CLS_J;
      default: cls_o = CLS_ILL;
    endcase
    illegal_o = (cls_o == CLS_ILL);
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle FSM sequencing FETCH/DECODE/EXEC/MEM/WB with a memory ready
// handshake, per-state datapath strobes and a retired-instruction counter.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter bit          EXT_ISA = 1'b1,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic [2:0]       alu_op,
  output logic [1:0]       ext_sel,
  output logic             alu_b_sel,
  output logic [2:0]       state,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  logic [ST_W-1:0]  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  instr_cls_e       cls;
  logic             cls_illegal;

  mc_ctrl_decode #(.EXT_ISA(EXT_ISA)) u_decode (
    .op_i      (op),
    .func_i    (func),
    .cls_o     (cls),
    .illegal_o (cls_illegal)
  );

  // Next state and strobes; reset forces every strobe low to abort cleanly.
  always_comb begin
    state_d    = ST_FETCH;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_sel     = PC_PLUS4;
    reg_write  = 1'b0;
    reg_dst    = REG_RT;
    wd_sel     = WD_ALU;
    alu_op     = ALU_AND;
    ext_sel    = EXT_ZERO;
    alu_b_sel  = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        state_d = ST_FETCH;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d = ST_EXEC;
        if (cls_illegal) begin
          illegal = 1'b1;
          state_d = ST_FETCH;
        end else if (cls inside {CLS_J, CLS_JAL, CLS_JR, CLS_JALR}) begin
          pc_write   = 1'b1;
          pc_sel     = (cls inside {CLS_J, CLS_JAL}) ? PC_JUMP : PC_RS;
          reg_write  = (cls inside {CLS_JAL, CLS_JALR});
          reg_dst    = (cls == CLS_JAL) ? REG_RA : REG_RD;
          wd_sel     = WD_PC;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end
      end
      ST_EXEC: begin
        state_d = ST_WB;
        case (cls)
          CLS_ADD: alu_op = ALU_ADD;
          CLS_SUB: alu_op = ALU_SUB;
          CLS_ORI: begin
            alu_op    = ALU_OR;
            ext_sel   = EXT_ZERO;
            alu_b_sel = 1'b1;
          end
          CLS_LUI: state_d = ST_WB;
          CLS_LW, CLS_SW: begin
            alu_op    = ALU_ADD;
            ext_sel   = EXT_SIGN;
            alu_b_sel = 1'b1;
            state_d   = ST_MEM;
          end
          CLS_BEQ, CLS_BNE: begin
            alu_op     = ALU_SUB;
            pc_write   = (cls == CLS_BEQ) ? zero : ~zero;
            pc_sel     = PC_BRANCH;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end
          default: state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (cls == CLS_SW);
        state_d = ST_MEM;
        if (mem_ready) begin
          instr_done = (cls == CLS_SW);
          state_d    = (cls == CLS_SW) ? ST_FETCH : ST_WB;
        end
      end
      ST_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (cls inside {CLS_ADD, CLS_SUB}) ? REG_RD : REG_RT;
        wd_sel     = (cls == CLS_LW) ? WD_MEM : (cls == CLS_LUI) ? WD_LUI : WD_ALU;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
    if (reset) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

  always_comb begin
    cnt_d = instr_done ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Random instruction streams against a per-instruction trace model, on one
// extended-ISA unit and one base-ISA unit with a narrow wrapping counter.
module tb_mc_control_unit;

  localparam int unsigned CW0 = 4;

  logic clk = 1'b0;
  logic reset, zero, mem_ready;
  logic [5:0] op, func;
  always #5 clk = ~clk;

  logic d1_req, d1_we, d1_irw, d1_pcw, d1_rw, d1_bsel, d1_done, d1_ill;
  logic [1:0] d1_pcs, d1_dst, d1_wd, d1_ext;
  logic [2:0] d1_alu, d1_st;
  logic [31:0] d1_cnt;
  logic d0_req, d0_we, d0_irw, d0_pcw, d0_rw, d0_bsel, d0_done, d0_ill;
  logic [1:0] d0_pcs, d0_dst, d0_wd, d0_ext;
  logic [2:0] d0_alu, d0_st;
  logic [CW0-1:0] d0_cnt;

  mc_control_unit #(.EXT_ISA(1'b1), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
    .mem_req(d1_req), .mem_we(d1_we), .ir_write(d1_irw), .pc_write(d1_pcw), .pc_sel(d1_pcs),
    .reg_write(d1_rw), .reg_dst(d1_dst), .wd_sel(d1_wd), .alu_op(d1_alu), .ext_sel(d1_ext),
    .alu_b_sel(d1_bsel), .state(d1_st), .instr_done(d1_done), .illegal(d1_ill),
    .instr_count(d1_cnt));

  mc_control_unit #(.EXT_ISA(1'b0), .CNT_W(CW0)) dut0 (
    .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
    .mem_req(d0_req), .mem_we(d0_we), .ir_write(d0_irw), .pc_write(d0_pcw), .pc_sel(d0_pcs),
    .reg_write(d0_rw), .reg_dst(d0_dst), .wd_sel(d0_wd), .alu_op(d0_alu), .ext_sel(d0_ext),
    .alu_b_sel(d0_bsel), .state(d0_st), .instr_done(d0_done), .illegal(d0_ill),
    .instr_count(d0_cnt));

  // Observe whichever unit the current phase targets.
  bit use0 = 1'b0;
  logic [6:0] o_strb;
  logic [2:0] o_st, o_alu;
  logic [1:0] o_pcs, o_dst, o_wd, o_ext;
  logic o_bsel;
  logic [31:0] o_cnt;
  always_comb begin
    if (use0) begin
      o_strb = {d0_req, d0_we, d0_irw, d0_pcw, d0_rw, d0_done, d0_ill};
      o_st = d0_st; o_alu = d0_alu; o_pcs = d0_pcs; o_dst = d0_dst;
      o_wd = d0_wd; o_ext = d0_ext; o_bsel = d0_bsel; o_cnt = 32'(d0_cnt);
    end else begin
      o_strb = {d1_req, d1_we, d1_irw, d1_pcw, d1_rw, d1_done, d1_ill};
      o_st = d1_st; o_alu = d1_alu; o_pcs = d1_pcs; o_dst = d1_dst;
      o_wd = d1_wd; o_ext = d1_ext; o_bsel = d1_bsel; o_cnt = d1_cnt;
    end
  end

  // Instruction ids: 0 add 1 sub 2 jr 3 lw 4 sw 5 beq 6 ori 7 lui 8 jal 9 bne 10 j 11 jalr 12 illegal
  typedef struct {
    bit [2:0] st;
    bit mem_req, mem_we, ir_w, pc_w, reg_w, done, ill;
    bit chk_pc, chk_alu;
    bit [1:0] pc_sel, reg_dst, wd_sel, ext_sel;
    bit [2:0] alu_op;
    bit b_sel, rdy, zin;
  } rec_t;

  rec_t exp_q[$];
  int n_cmp = 0, n_err = 0, cyc = 0;
  int unsigned model_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic rec_t blank(input bit [2:0] st);
    rec_t r;
    r = '{default: 0};
    r.st = st;
    r.rdy = 1'($urandom);
    r.zin = 1'($urandom);
    return r;
  endfunction

  function automatic logic [11:0] encode(input int c);
    logic [5:0] f;
    f = 6'($urandom);
    case (c)
      0: return {6'b000000, 6'b100000};
      1: return {6'b000000, 6'b100010};
      2: return {6'b000000, 6'b001000};
      3: return {6'b100011, f};
      4: return {6'b101011, f};
      5: return {6'b000100, f};
      6: return {6'b001101, f};
      7: return {6'b001111, f};
      8: return {6'b000011, f};
      9: return {6'b000101, f};
      10: return {6'b000010, f};
      11: return {6'b000000, 6'b001001};
      default: return ($urandom_range(0, 1) == 0) ? {6'b111111, f} : {6'b000000, 6'b000000};
    endcase
  endfunction

  // Expected cycle-by-cycle trace of one instruction from its class and wait counts.
  task automatic build(input int c, input int fw, input int mw, input bit z, input bit ext);
    rec_t r;
    bit ill;
    ill = (c == 12) || (c >= 9 && c <= 11 && !ext);
    for (int i = 0; i < fw; i++) begin
      r = blank(3'd0); r.mem_req = 1; r.rdy = 0; exp_q.push_back(r);
    end
    r = blank(3'd0); r.mem_req = 1; r.rdy = 1; r.ir_w = 1; r.pc_w = 1; r.chk_pc = 1;
    r.pc_sel = 2'b00; exp_q.push_back(r);
    r = blank(3'd1);
    if (ill) begin r.ill = 1; exp_q.push_back(r); return; end
    if (c == 2 || c == 8 || c == 10 || c == 11) begin
      r.pc_w = 1; r.chk_pc = 1; r.done = 1;
      r.pc_sel = (c == 8 || c == 10) ? 2'b10 : 2'b11;
      if (c == 8) begin r.reg_w = 1; r.reg_dst = 2'b10; r.wd_sel = 2'b11; end
      if (c == 11) begin r.reg_w = 1; r.reg_dst = 2'b01; r.wd_sel = 2'b11; end
      exp_q.push_back(r); return;
    end
    exp_q.push_back(r);
    r = blank(3'd2); r.chk_alu = 1;
    case (c)
      0: r.alu_op = 3'd2;
      1, 5, 9: r.alu_op = 3'd3;
      6: begin r.alu_op = 3'd1; r.ext_sel = 2'b00; r.b_sel = 1; end
      3, 4: begin r.alu_op = 3'd2; r.ext_sel = 2'b01; r.b_sel = 1; end
      default: r.chk_alu = 0;
    endcase
    if (c == 5 || c == 9) begin
      r.zin = z; r.pc_w = (c == 5) ? z : !z; r.chk_pc = 1; r.pc_sel = 2'b01; r.done = 1;
      exp_q.push_back(r); return;
    end
    exp_q.push_back(r);
    if (c == 3 || c == 4) begin
      for (int i = 0; i <= mw; i++) begin
        r = blank(3'd3); r.mem_req = 1; r.mem_we = (c == 4); r.rdy = (i == mw);
        r.done = (i == mw) && (c == 4);
        exp_q.push_back(r);
      end
      if (c == 4) return;
    end
    r = blank(3'd4); r.reg_w = 1; r.done = 1;
    r.reg_dst = (c == 0 || c == 1) ? 2'b01 : 2'b00;
    r.wd_sel = (c == 3) ? 2'b01 : (c == 7) ? 2'b10 : 2'b00;
    exp_q.push_back(r);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      mem_ready = 1'($urandom); zero = 1'($urandom); op = 6'($urandom); func = 6'($urandom);
      @(negedge clk);
      check_eq("reset_strobes", 32'(o_strb), 32'h0);
      @(posedge clk); #1; cyc++;
    end
    reset = 1'b0;
    model_cnt = 0;
  endtask

  task automatic run_trace(input logic [5:0] op_v, input logic [5:0] fn_v, input int abort_at);
    rec_t r;
    logic [6:0] es;
    logic [31:0] mask;
    mask = use0 ? 32'((1 << CW0) - 1) : 32'hFFFF_FFFF;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == abort_at) break;
      r = exp_q[i];
      mem_ready = r.rdy; zero = r.zin;
      if (r.st == 3'd0) begin op = 6'($urandom); func = 6'($urandom); end
      else begin op = op_v; func = fn_v; end
      @(negedge clk);
      es = {r.mem_req, r.mem_we, r.ir_w, r.pc_w, r.reg_w, r.done, r.ill};
      check_eq("state", 32'(o_st), 32'(r.st));
      check_eq("strobes", 32'(o_strb), 32'(es));
      if (r.chk_pc) check_eq("pc_sel", 32'(o_pcs), 32'(r.pc_sel));
      if (r.reg_w) check_eq("reg_dst/wd_sel", 32'({o_dst, o_wd}), 32'({r.reg_dst, r.wd_sel}));
      if (r.chk_alu)
        check_eq("alu_ctl", 32'({o_alu, o_ext, o_bsel}), 32'({r.alu_op, r.ext_sel, r.b_sel}));
      check_eq("instr_count", o_cnt, model_cnt & mask);
      if (r.done) model_cnt++;
      @(posedge clk); #1; cyc++;
    end
  endtask

  // abort_at: -1 run to completion, -2 random abort point, >=0 abort before that cycle
  task automatic run_one(input int c, input int fw, input int mw, input bit z, input int abort_at);
    logic [11:0] e;
    int ab;
    exp_q.delete();
    build(c, fw, mw, z, !use0);
    e = encode(c);
    ab = (abort_at == -2) ? $urandom_range(0, exp_q.size() - 1) : abort_at;
    run_trace(e[11:6], e[5:0], ab);
    if (ab >= 0) do_reset($urandom_range(1, 2));
  endtask

  task automatic run_random(input int n);
    for (int k = 0; k < n; k++)
      run_one($urandom_range(0, 12), $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0,
              $urandom_range(0, 3), 1'($urandom), ($urandom_range(0, 15) == 0) ? -2 : -1);
  endtask

  initial begin
    reset = 1'b1; zero = 1'b0; mem_ready = 1'b0; op = '0; func = '0;
    do_reset(2);
    run_one(0, 0, 0, 0, -1);
    run_one(3, 0, 2, 0, -1);
    run_one(5, 0, 0, 1, -1);
    run_one(5, 0, 0, 0, -1);
    run_one(8, 0, 0, 0, -1);
    run_one(9, 0, 0, 1, -1);
    run_one(11, 2, 0, 0, -1);
    run_one(4, 1, 2, 0, 4);
    run_random(350);
    use0 = 1'b1;
    do_reset(2);
    run_one(9, 0, 0, 0, -1);
    run_one(10, 0, 0, 0, -1);
    run_one(11, 0, 0, 0, -1);
    run_random(250);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
